mips_data_mem: RTL and testbench

- Byte-addressable data memory for the single-cycle MIPS core. It is the responder end of the core's load/store port.
- Reads are combinational, so loads complete in the same cycle. Writes commit on the clock edge across four byte lanes.
- After reset it clears its own contents before accepting traffic.
- When the core halts, it streams the whole memory image out on a valid/ready dump port, for checking by the testbench or a debug link.

---
 rtl/mips_data_mem.sv | 133 +++++++++++++
 tb/tb_mips_data_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - byte-addressable MIPS data memory with clear sweep and dump port
module mips_data_mem #(
  parameter int ADDR_BITS      = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          mem_addr,
  input  logic [3:0][7:0]      mem_data_in,
  input  logic                 mem_write_en,
  output logic [3:0][7:0]      mem_data_out,
  input  logic                 halted,
  output logic                 init_done,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_BITS-1:0] dump_addr,
  output logic [31:0]          dump_data,
  output logic                 dump_done
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int W_BITS = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1;
  localparam logic [W_BITS-1:0]    W_LAST = W_BITS'(DEPTH / 4 - 1);
  localparam logic [ADDR_BITS-1:0] P_LAST = ADDR_BITS'(DEPTH - 4);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]                mem [DEPTH];
  logic [W_BITS-1:0]         w;
  logic [ADDR_BITS-1:0]      p;
  logic [ADDR_BITS-1:0]      base;
  logic [ADDR_BITS-1:0]      clear_base;
  logic [3:0][ADDR_BITS-1:0] lane_idx;
  logic [3:0][ADDR_BITS-1:0] clear_idx;
  logic                      accept;
  logic                      user_write;
  logic                      unused_addr_bits;

  // Upper address bits beyond the decoded range are intentionally ignored.
  assign unused_addr_bits = ^mem_addr[31:ADDR_BITS];

  assign base       = mem_addr[ADDR_BITS-1:0];
  assign clear_base = ADDR_BITS'({w, 2'b00});
  assign dump_valid = (state == ST_DUMP);
  assign dump_done  = (state == ST_DONE);
  assign dump_addr  = p;
  assign accept     = dump_valid && dump_ready;
  // Core writes only land outside the clear sweep and the dump.
  assign user_write = mem_write_en && ((state == ST_RUN) || (state == ST_DONE));

  // Per-lane byte indices; unaligned accesses wrap modulo the memory depth.
  always_comb begin
    lane_idx  = '0;
    clear_idx = '0;
    for (int i = 0; i < 4; i++) begin
      lane_idx[i]  = base + ADDR_BITS'(i);
      clear_idx[i] = clear_base + ADDR_BITS'(i);
    end
  end

  // Combinational read port, forced to zero while the sweep is clearing.
  always_comb begin
    mem_data_out = '0;
    if (state != ST_INIT) begin
      for (int i = 0; i < 4; i++) begin
        mem_data_out[i] = mem[lane_idx[i]];
      end
    end
  end

  // Dump word is big-endian from the pointer, zero when no word is offered.
  always_comb begin
    dump_data = '0;
    if (dump_valid) begin
      dump_data = {mem[p], mem[p + ADDR_BITS'(1)],
                   mem[p + ADDR_BITS'(2)], mem[p + ADDR_BITS'(3)]};
    end
  end

  // Next-state logic: sweep, run, dump until the last word is taken, then park.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (w == W_LAST) state_nxt = ST_RUN;
      ST_RUN:  if (halted) state_nxt = ST_DUMP;
      ST_DUMP: if (accept && (p == P_LAST)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Control registers; reset aborts any sweep or dump in progress.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      w         <= '0;
      p         <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt != ST_INIT);
      if (state == ST_INIT) begin
        w <= w + W_BITS'(1);
      end
      if (state == ST_RUN) begin
        p <= '0;
      end else if (accept && (p != P_LAST)) begin
        p <= p + ADDR_BITS'(4);
      end
    end
  end

  // Byte array: one word zeroed per sweep cycle, or four core lanes written.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      for (int i = 0; i < 4; i++) begin
        mem[clear_idx[i]] <= 8'h00;
      end
    end else if (user_write) begin
      for (int i = 0; i < 4; i++) begin
        mem[lane_idx[i]] <= mem_data_in[i];
      end
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - randomized self-checking bench for mips_data_mem
module tb_mips_data_mem;

  localparam int AB    = 6;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic            mem_write_en;
  logic [3:0][7:0] mem_data_out;
  logic            halted;
  logic            init_done;
  logic            dump_valid;
  logic            dump_ready;
  logic [AB-1:0]   dump_addr;
  logic [31:0]     dump_data;
  logic            dump_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [DEPTH];

  mips_data_mem #(
    .ADDR_BITS(AB),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .halted(halted),
    .init_done(init_done),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr(dump_addr),
    .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_be();
    return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {ref_mem[a % DEPTH], ref_mem[(a + 1) % DEPTH],
            ref_mem[(a + 2) % DEPTH], ref_mem[(a + 3) % DEPTH]};
  endfunction

  task automatic model_write(input int a, input logic [31:0] d);
    ref_mem[a % DEPTH]       = d[31:24];
    ref_mem[(a + 1) % DEPTH] = d[23:16];
    ref_mem[(a + 2) % DEPTH] = d[15:8];
    ref_mem[(a + 3) % DEPTH] = d[7:0];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    mem_addr       = a;
    mem_data_in[0] = d[31:24];
    mem_data_in[1] = d[23:16];
    mem_data_in[2] = d[15:8];
    mem_data_in[3] = d[7:0];
    mem_write_en   = we;
    #1;
  endtask

  task automatic reset_init(input bit lost_write);
    rst_b      = 1'b0;
    halted     = 1'b0;
    dump_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    step();
    step();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    check("rst_dump_addr", 32'(dump_addr), 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("rst_read_zero", rd_be(), 32'd0);
    rst_b = 1'b1;
    if (lost_write) drive(32'h08, 32'hAABBCCDD, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 5)  check("init_read_zero", rd_be(), 32'd0);
      if (k == 15) check("init_done_early", 32'(init_done), 32'd0);
    end
    check("init_done_16", 32'(init_done), 32'd1);
    drive(32'h08, 32'h0, 1'b0);
    model_clear();
    check("init_write_lost", rd_be(), model_word(8));
  endtask

  initial begin
    int          a;
    logic [31:0] d;
    logic        we;
    int          ptr;
    int          cyc;
    int          beats;
    logic [3:0]  ready_pat;

    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    dump_ready   = 1'b0;
    ready_pat    = 4'b1001;

    reset_init(1'b1);

    drive(32'h10, 32'h11223344, 1'b1);
    check("rw_same_cycle_old", rd_be(), 32'h00000000);
    step();
    model_write(16, 32'h11223344);
    drive(32'h10, 32'h0, 1'b0);
    check("rw_next_cycle", rd_be(), 32'h11223344);
    drive(32'h11, 32'h0, 1'b0);
    check("unaligned_read", rd_be(), 32'h22334400);

    drive(32'h3E, 32'h01020304, 1'b1);
    step();
    model_write(62, 32'h01020304);
    drive(32'h00, 32'h0, 1'b0);
    check("wrap_read_low", rd_be(), 32'h03040000);
    drive(32'h3E, 32'h0, 1'b0);
    check("wrap_read_top", rd_be(), 32'h01020304);

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = we ? int'($urandom_range(24, 52)) : int'($urandom_range(0, 63));
      d  = $urandom;
      drive(32'(a), d, we);
      check("rand_read", rd_be(), model_word(a));
      step();
      if (we) model_write(a, d);
    end

    halted = 1'b1;
    drive(32'h20, 32'hCAFEF00D, 1'b1);
    step();
    model_write(32, 32'hCAFEF00D);
    halted     = 1'b0;
    dump_ready = 1'b1;
    drive(32'h28, 32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check("dump1_valid", 32'(dump_valid), 32'd1);
      check("dump1_addr", 32'(dump_addr), 32'(4 * k));
      check("dump1_data", dump_data, model_word(4 * k));
      if (k == 0)  check("dump1_beat00", dump_data, 32'h03040000);
      if (k == 4)  check("dump1_beat10", dump_data, 32'h11223344);
      if (k == 15) check("dump1_beat3c", dump_data, 32'h00000102);
      step();
    end
    check("dump1_done", 32'(dump_done), 32'd1);
    check("dump1_valid_low", 32'(dump_valid), 32'd0);
    drive(32'h28, 32'h0, 1'b0);
    check("dump_write_ignored", rd_be(), model_word(40));
    drive(32'h28, 32'h5A5A5A5A, 1'b1);
    step();
    model_write(40, 32'h5A5A5A5A);
    drive(32'h28, 32'h0, 1'b0);
    check("done_write", rd_be(), model_word(40));

    reset_init(1'b0);
    for (int n = 0; n < 6; n++) begin
      a = int'($urandom_range(0, 63));
      d = $urandom;
      drive(32'(a), d, 1'b1);
      step();
      model_write(a, d);
    end
    drive(32'h0, 32'h0, 1'b0);
    halted = 1'b1;
    step();
    halted = 1'b0;
    ptr   = 0;
    cyc   = 0;
    beats = 0;
    while (ptr < DEPTH && cyc < 200) begin
      dump_ready = ready_pat[cyc % 4];
      #1;
      check("bp_valid", 32'(dump_valid), 32'd1);
      check("bp_addr", 32'(dump_addr), 32'(ptr));
      check("bp_data", dump_data, model_word(ptr));
      step();
      if (dump_ready) begin
        ptr   += 4;
        beats += 1;
      end
      cyc++;
    end
    dump_ready = 1'b0;
    check("bp_beats", 32'(beats), 32'd16);
    check("bp_done", 32'(dump_done), 32'd1);

    reset_init(1'b0);
    drive(32'h10, 32'h11223344, 1'b1);
    step();
    model_write(16, 32'h11223344);
    drive(32'h0, 32'h0, 1'b0);
    halted = 1'b1;
    step();
    halted     = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("abort_beat5_valid", 32'(dump_valid), 32'd1);
    check("abort_beat5_addr", 32'(dump_addr), 32'h14);
    rst_b = 1'b0;
    #1;
    check("abort_valid_drop", 32'(dump_valid), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_dump_addr", 32'(dump_addr), 32'd0);
    check("abort_read_zero", rd_be(), 32'd0);
    step();
    step();
    rst_b      = 1'b1;
    dump_ready = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    model_clear();
    check("abort_reinit_done", 32'(init_done), 32'd1);
    drive(32'h10, 32'h0, 1'b0);
    check("abort_read_cleared", rd_be(), model_word(16));
    check("abort_dump_done", 32'(dump_done), 32'd0);
    check("abort_dump_valid", 32'(dump_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
